// File: rtl/error_checker_sequencer.sv
// Sample sequencer for the linear-regression error checker: starts a pass, feeds (x, y)
// samples from sample memory on each checker ready, and reports pass completion.
module error_checker_sequencer #(
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              en,
    output logic              cout,
    input  logic              error_checker_ready,
    input  logic              error_checker_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_x,
    input  logic [DATA_W-1:0] mem_y,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic              sample_valid,
    output logic [ADDR_W:0]   sample_cnt,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W:0] SAMPLE_LAST = (ADDR_W + 1)'(N_SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_RDY,
        FETCH,
        LATCH,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;
    logic   fetch_go;
    logic   latch_go;
    logic   pass_clear;
    logic   overrun_set;

    // The counter is one bit wider than the address so a full memory pass does not wrap.
    assign cout = (sample_cnt == SAMPLE_LAST);

    always_comb begin
        state_next  = state;
        fetch_go    = 1'b0;
        latch_go    = 1'b0;
        pass_clear  = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pass_clear = 1'b1;
                    state_next = PULSE;
                end
            end
            PULSE:    state_next = WAIT_RDY;
            WAIT_RDY: begin
                if (error_checker_ready) begin
                    if (cout) begin
                        state_next = WAIT_DONE;
                    end else begin
                        fetch_go   = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                overrun_set = error_checker_ready;
                state_next  = LATCH;
            end
            LATCH: begin
                overrun_set = error_checker_ready;
                latch_go    = 1'b1;
                state_next  = WAIT_RDY;
            end
            WAIT_DONE: begin
                if (error_checker_done) begin
                    state_next = FINISH;
                end
            end
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            en           <= 1'b0;
            done         <= 1'b0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            sample_valid <= 1'b0;
            sample_cnt   <= '0;
            overrun      <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != IDLE);
            en           <= (state == PULSE);
            done         <= (state_next == FINISH);
            mem_rd       <= fetch_go;
            sample_valid <= latch_go;
            if (fetch_go) begin
                mem_addr <= sample_cnt[ADDR_W-1:0];
            end
            // Read data from the fetch issued two cycles earlier is present during LATCH.
            if (latch_go) begin
                x_out <= mem_x;
                y_out <= mem_y;
            end
            if (pass_clear) begin
                sample_cnt <= '0;
            end else if (latch_go) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (pass_clear) begin
                overrun <= 1'b0;
            end else if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_error_checker_sequencer.sv
// Directed bench for error_checker_sequencer: a cycle table for a 4-sample pass plus
// hand-written sequences for overrun, early done, and reset mid-pass.
module tb_error_checker_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, rdy, dn;

    // a: N=4, ADDR_W=8   b: N=4=2^ADDR_W, ADDR_W=2   c: N=0
    logic        busy_a, en_a, cout_a, rd_a, sv_a, done_a, ovr_a;
    logic [7:0]  addr_a;
    logic [19:0] mx_a, my_a, x_a, y_a;
    logic [8:0]  cnt_a;
    logic        busy_b, en_b, cout_b, rd_b, sv_b, done_b, ovr_b;
    logic [1:0]  addr_b;
    logic [19:0] mx_b, my_b, x_b, y_b;
    logic [2:0]  cnt_b;
    logic        busy_c, en_c, cout_c, rd_c, sv_c, done_c, ovr_c;
    logic [7:0]  addr_c;
    logic [19:0] mx_c, my_c, x_c, y_c;
    logic [8:0]  cnt_c;

    error_checker_sequencer #(.N_SAMPLES(4), .ADDR_W(8), .DATA_W(20)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .en(en_a), .cout(cout_a),
        .error_checker_ready(rdy), .error_checker_done(dn), .mem_rd(rd_a), .mem_addr(addr_a),
        .mem_x(mx_a), .mem_y(my_a), .x_out(x_a), .y_out(y_a), .sample_valid(sv_a),
        .sample_cnt(cnt_a), .done(done_a), .overrun(ovr_a));

    error_checker_sequencer #(.N_SAMPLES(4), .ADDR_W(2), .DATA_W(20)) u_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .en(en_b), .cout(cout_b),
        .error_checker_ready(rdy), .error_checker_done(dn), .mem_rd(rd_b), .mem_addr(addr_b),
        .mem_x(mx_b), .mem_y(my_b), .x_out(x_b), .y_out(y_b), .sample_valid(sv_b),
        .sample_cnt(cnt_b), .done(done_b), .overrun(ovr_b));

    error_checker_sequencer #(.N_SAMPLES(0), .ADDR_W(8), .DATA_W(20)) u_c (
        .clk(clk), .rst(rst), .start(start), .busy(busy_c), .en(en_c), .cout(cout_c),
        .error_checker_ready(rdy), .error_checker_done(dn), .mem_rd(rd_c), .mem_addr(addr_c),
        .mem_x(mx_c), .mem_y(my_c), .x_out(x_c), .y_out(y_c), .sample_valid(sv_c),
        .sample_cnt(cnt_c), .done(done_c), .overrun(ovr_c));

    function automatic logic [19:0] fx(input int a);
        return 20'h10000 + 20'(a * 7);
    endfunction

    function automatic logic [19:0] fy(input int a);
        return 20'hF0F00 ^ 20'(a);
    endfunction

    // Sample memories: read data appears the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (rd_a) begin mx_a <= fx(int'(addr_a)); my_a <= fy(int'(addr_a)); end
        if (rd_b) begin mx_b <= fx(int'(addr_b)); my_b <= fy(int'(addr_b)); end
        if (rd_c) begin mx_c <= fx(int'(addr_c)); my_c <= fy(int'(addr_c)); end
    end

    int rd_cnt_a = 0;
    int done_cnt_a = 0;
    always @(negedge clk) begin
        if (rd_a)   rd_cnt_a   <= rd_cnt_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic d);
        @(negedge clk);
        start = s; rdy = r; dn = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic start, rdy, dn;
        logic busy, en, rd;
        int   addr;
        logic sv;
        int   cnt;
        logic cout, done;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic d, input logic b,
                                input logic e, input logic rd, input int addr, input logic sv,
                                input int cnt, input logic co, input logic dno);
        vec_t v;
        v.start = s; v.rdy = r; v.dn = d; v.busy = b; v.en = e; v.rd = rd;
        v.addr = addr; v.sv = sv; v.cnt = cnt; v.cout = co; v.done = dno;
        return v;
    endfunction

    vec_t vecs[33];
    logic [19:0] ex, ey;
    int rb, db;

    initial begin
        // Main pass, one row per clock: inputs, then outputs after that edge.
        vecs[0]  = mk(1,0,0, 1,0,0,0,0,0,0,0);
        vecs[1]  = mk(1,0,0, 1,1,0,0,0,0,0,0);
        vecs[2]  = mk(1,0,0, 1,0,0,0,0,0,0,0);
        vecs[3]  = mk(1,1,0, 1,0,1,0,0,0,0,0);
        vecs[4]  = mk(1,0,0, 1,0,0,0,0,0,0,0);
        vecs[5]  = mk(1,0,0, 1,0,0,0,1,1,0,0);
        vecs[6]  = mk(1,0,0, 1,0,0,0,0,1,0,0);
        vecs[7]  = mk(1,0,0, 1,0,0,0,0,1,0,0);
        vecs[8]  = mk(1,0,0, 1,0,0,0,0,1,0,0);
        vecs[9]  = mk(1,1,0, 1,0,1,1,0,1,0,0);
        vecs[10] = mk(1,0,0, 1,0,0,1,0,1,0,0);
        vecs[11] = mk(0,0,0, 1,0,0,1,1,2,0,0);
        vecs[12] = mk(0,0,0, 1,0,0,1,0,2,0,0);
        vecs[13] = mk(0,0,0, 1,0,0,1,0,2,0,0);
        vecs[14] = mk(0,0,0, 1,0,0,1,0,2,0,0);
        vecs[15] = mk(0,1,0, 1,0,1,2,0,2,0,0);
        vecs[16] = mk(0,0,0, 1,0,0,2,0,2,0,0);
        vecs[17] = mk(0,0,0, 1,0,0,2,1,3,0,0);
        vecs[18] = mk(0,0,0, 1,0,0,2,0,3,0,0);
        vecs[19] = mk(0,0,0, 1,0,0,2,0,3,0,0);
        vecs[20] = mk(0,0,0, 1,0,0,2,0,3,0,0);
        vecs[21] = mk(0,1,0, 1,0,1,3,0,3,0,0);
        vecs[22] = mk(0,0,0, 1,0,0,3,0,3,0,0);
        vecs[23] = mk(0,0,0, 1,0,0,3,1,4,1,0);
        vecs[24] = mk(0,0,0, 1,0,0,3,0,4,1,0);
        vecs[25] = mk(0,0,0, 1,0,0,3,0,4,1,0);
        vecs[26] = mk(0,0,0, 1,0,0,3,0,4,1,0);
        vecs[27] = mk(0,1,0, 1,0,0,3,0,4,1,0);
        vecs[28] = mk(0,0,0, 1,0,0,3,0,4,1,0);
        vecs[29] = mk(0,0,0, 1,0,0,3,0,4,1,0);
        vecs[30] = mk(0,0,1, 1,0,0,3,0,4,1,1);
        vecs[31] = mk(1,0,0, 0,0,0,3,0,4,1,0);
        vecs[32] = mk(0,0,0, 0,0,0,3,0,4,1,0);

        rst = 1'b0; start = 1'b0; rdy = 1'b0; dn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);   chk("rst_en", en_a, 0);      chk("rst_rd", rd_a, 0);
        chk("rst_addr", addr_a, 0);   chk("rst_x", x_a, 0);        chk("rst_sv", sv_a, 0);
        chk("rst_cnt", cnt_a, 0);     chk("rst_done", done_a, 0);  chk("rst_ovr", ovr_a, 0);
        chk("rst_cout_a", cout_a, 0); chk("rst_cout_c", cout_c, 1);
        @(negedge clk);
        rst = 1'b1;

        ex = '0; ey = '0;
        for (int i = 0; i < 33; i++) begin
            cyc(vecs[i].start, vecs[i].rdy, vecs[i].dn);
            if (vecs[i].sv) begin
                ex = fx(vecs[i].cnt - 1);
                ey = fy(vecs[i].cnt - 1);
            end
            chk($sformatf("t%0d_busy", i), busy_a, vecs[i].busy);
            chk($sformatf("t%0d_en", i), en_a, vecs[i].en);
            chk($sformatf("t%0d_rd", i), rd_a, vecs[i].rd);
            chk($sformatf("t%0d_addr", i), addr_a, vecs[i].addr);
            chk($sformatf("t%0d_sv", i), sv_a, vecs[i].sv);
            chk($sformatf("t%0d_cnt", i), cnt_a, vecs[i].cnt);
            chk($sformatf("t%0d_cout", i), cout_a, vecs[i].cout);
            chk($sformatf("t%0d_done", i), done_a, vecs[i].done);
            chk($sformatf("t%0d_ovr", i), ovr_a, 0);
            chk($sformatf("t%0d_x", i), x_a, ex);
            chk($sformatf("t%0d_y", i), y_a, ey);
            chk($sformatf("t%0d_full_addr", i), addr_b, vecs[i].addr);
            chk($sformatf("t%0d_full_cnt", i), cnt_b, vecs[i].cnt);
            chk($sformatf("t%0d_full_cout", i), cout_b, vecs[i].cout);
            chk($sformatf("t%0d_full_x", i), x_b, ex);
            chk($sformatf("t%0d_n0_busy", i), busy_c, vecs[i].busy);
            chk($sformatf("t%0d_n0_en", i), en_c, vecs[i].en);
            chk($sformatf("t%0d_n0_done", i), done_c, vecs[i].done);
            chk($sformatf("t%0d_n0_rd", i), rd_c, 0);
            chk($sformatf("t%0d_n0_sv", i), sv_c, 0);
            chk($sformatf("t%0d_n0_cout", i), cout_c, 1);
        end

        // Overrun: ready repeated while the fetch is in flight.
        rb = rd_cnt_a;
        cyc(1,0,0);
        chk("ovr_start_cnt", cnt_a, 0); chk("ovr_start_cout", cout_a, 0); chk("ovr_start_flag", ovr_a, 0);
        cyc(0,0,0);
        cyc(0,1,0); chk("ovr_fetch_rd", rd_a, 1);
        cyc(0,1,0); chk("ovr_set", ovr_a, 1); chk("ovr_no_rd", rd_a, 0); chk("ovr_n0_clear", ovr_c, 0);
        cyc(0,0,0); chk("ovr_sv", sv_a, 1); chk("ovr_cnt", cnt_a, 1); chk("ovr_reads", rd_cnt_a - rb, 1);
        cyc(0,0,1); chk("early_done_busy", busy_a, 1); chk("early_done", done_a, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0,1,0); cyc(0,0,0); cyc(0,0,0);
        end
        chk("ovr_cnt4", cnt_a, 4); chk("ovr_cout", cout_a, 1); chk("ovr_x_last", x_a, fx(3));
        cyc(0,1,0);
        cyc(0,0,1); chk("ovr_done", done_a, 1); chk("ovr_held_done", ovr_a, 1);
        cyc(0,0,0); chk("ovr_held_idle", ovr_a, 1); chk("ovr_idle_busy", busy_a, 0);
        chk("ovr_pass_reads", rd_cnt_a - rb, 4);

        // Reset during LATCH of the second sample.
        cyc(1,0,0); chk("rs_ovr_cleared", ovr_a, 0);
        cyc(0,0,0);
        cyc(0,1,0); cyc(0,0,0); cyc(0,0,0);
        cyc(0,1,0); chk("rs_addr1", addr_a, 1);
        cyc(0,0,0);
        #2 rst = 1'b0;
        #1;
        chk("rs_busy", busy_a, 0); chk("rs_en", en_a, 0);   chk("rs_rd", rd_a, 0);
        chk("rs_addr", addr_a, 0); chk("rs_x", x_a, 0);     chk("rs_y", y_a, 0);
        chk("rs_sv", sv_a, 0);     chk("rs_cnt", cnt_a, 0); chk("rs_done", done_a, 0);
        chk("rs_ovr", ovr_a, 0);
        rb = rd_cnt_a; db = done_cnt_a;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) cyc(0,0,0);
        chk("rs_no_reads", rd_cnt_a - rb, 0); chk("rs_no_done", done_cnt_a - db, 0);
        chk("rs_idle", busy_a, 0);
        cyc(1,0,0); chk("rs_restart_busy", busy_a, 1);
        cyc(0,0,0);
        cyc(0,1,0); chk("rs_restart_rd", rd_a, 1); chk("rs_restart_addr", addr_a, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/error_checker_sequencer.md
Name: error_checker_sequencer

Overview:
- Initiator and data source for the error-checker controller in the linear-regression datapath.
- On a start request, it pulses `en` into the checker. Each time the checker raises `error_checker_ready`, it fetches the next (x, y) sample from sample memory, presents the sample, and drives `cout` to tell the checker whether samples remain.
- When `error_checker_done` arrives, it reports completion to the top-level controller.

Parameters:
- N_SAMPLES, 150, number of samples per pass; legal range 0..2^ADDR_W.
- ADDR_W, 8, sample-memory address width.
- DATA_W, 20, width of x and y sample words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a pass; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until the FINISH cycle inclusive.
- en  out  1  enable to the error checker.
- cout  out  1  "no samples remain" indication to the checker.
- error_checker_ready  in  1  checker requests the next sample.
- error_checker_done  in  1  checker idle / pass complete.
- mem_rd  out  1  sample-memory read strobe.
- mem_addr  out  ADDR_W  sample-memory read address.
- mem_x  in  DATA_W  x read data; valid 1 cycle after mem_rd.
- mem_y  in  DATA_W  y read data; valid 1 cycle after mem_rd.
- x_out  out  DATA_W  registered x presented to the datapath.
- y_out  out  DATA_W  registered y presented to the datapath.
- sample_valid  out  1  one-cycle pulse when x_out/y_out update.
- sample_cnt  out  ADDR_W+1  number of samples delivered this pass.
- done  out  1  one-cycle pass-complete pulse.
- overrun  out  1  sticky protocol-error flag; cleared when start is accepted.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state=IDLE, counter=0.
- All outputs are registered, except `cout`, which is combinational: `cout = (sample_cnt == N_SAMPLES)`.
- IDLE:
  - busy=0.
  - On start=1: clear sample_cnt, clear overrun, go to PULSE.
- PULSE:
  - en=1 for exactly this cycle, then go to WAIT_RDY.
  - The checker moves S0->S1 on en and S1->S2 when en drops, so its ready appears 2 cycles after PULSE.
- WAIT_RDY, on error_checker_ready=1:
  - If sample_cnt==N_SAMPLES: go to WAIT_DONE. cout=1 in this cycle returns the checker to its idle state.
  - Else: mem_rd=1, mem_addr=sample_cnt[ADDR_W-1:0], go to FETCH.
  - If error_checker_ready=0: stay.
- FETCH: wait state covering the 1-cycle memory read latency; go to LATCH.
- LATCH:
  - Capture x_out<=mem_x and y_out<=mem_y.
  - sample_valid=1 for one cycle.
  - sample_cnt<=sample_cnt+1.
  - Go to WAIT_RDY.
  - Total ready-to-sample_valid latency: 2 cycles. This fits inside the checker's wait/load window (at least 3 cycles before h_ld).
- WAIT_DONE: on error_checker_done=1, go to FINISH.
- FINISH: done=1 for one cycle; go to IDLE. busy is still 1 in this cycle.
- x_out/y_out hold their last sample until the next LATCH or reset. They are not cleared at start.
- mem_addr holds its last value when mem_rd=0.
- Boundary conditions:
  - error_checker_ready=1 while in FETCH or LATCH: set overrun=1 and ignore the pulse (no extra fetch, no state change).
  - overrun stays set until the next accepted start or reset.
  - N_SAMPLES=0: the first ready sees cout=1; no memory read and no sample_valid; the pass proceeds WAIT_DONE -> FINISH.
  - Last sample: after the LATCH that makes sample_cnt==N_SAMPLES, cout=1 before the next ready.
  - N_SAMPLES=2^ADDR_W: sample_cnt reaches 2^ADDR_W without wrap. The address uses the low ADDR_W bits, so the maximum address read is 2^ADDR_W-1.
  - start while busy=1: ignored, no effect on the count.
  - start in the same cycle FINISH exits to IDLE: ignored; start is sampled only in IDLE.
  - error_checker_done seen outside WAIT_DONE: ignored.
  - Reset mid-pass: immediate return to IDLE. No done pulse and no further memory reads after reset deasserts.

Test Plan:
- Normal pass, N_SAMPLES=4, checker model giving a ready every 6 cycles:
  - Check mem_addr sequence 0,1,2,3.
  - Check four sample_valid pulses, each 2 cycles after its ready, with x_out/y_out equal to memory contents.
  - cout=1 after the 4th LATCH; done pulses once; sample_cnt=4; overrun=0.
- en timing: start at cycle t -> en=1 only at cycle t+2 (PULSE registered) -> busy=1 from t+1 through FINISH.
- N_SAMPLES=0: start -> en pulse -> first ready -> cout=1, mem_rd never asserted, sample_valid never pulses, then done.
- Overrun: ready asserted during FETCH -> overrun=1; fetch count unchanged; overrun stays set through done; next start clears it.
- Reset mid-pass: rst=0 in LATCH of sample 2 -> all outputs 0 immediately; after release, start yields a fresh pass with mem_addr starting at 0.
- start held high for 10 cycles during a pass -> single pass, single done.
